// File: rtl/morse_pkg.sv
// Shared types and the Morse-to-ASCII table for the straight-key decoder.
package morse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MARK = 2'd1,
    ST_GAP  = 2'd2,
    ST_WORD = 2'd3
  } state_t;

  localparam logic [7:0] ASCII_SPACE   = 8'h20;
  localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;

  // Pattern holds symbols LSB-last: the first keyed symbol ends up most significant.
  function automatic logic [7:0] morse_lookup(input logic [2:0] len, input logic [6:0] pattern);
    logic [7:0] ch;
    ch = ASCII_UNKNOWN;
    if (pattern[6:5] == 2'b00) begin
      case ({len, pattern[4:0]})
        {3'd1, 5'b00000}: ch = 8'h45; // E
        {3'd1, 5'b00001}: ch = 8'h54; // T
        {3'd2, 5'b00000}: ch = 8'h49; // I
        {3'd2, 5'b00001}: ch = 8'h41; // A
        {3'd2, 5'b00010}: ch = 8'h4E; // N
        {3'd2, 5'b00011}: ch = 8'h4D; // M
        {3'd3, 5'b00000}: ch = 8'h53; // S
        {3'd3, 5'b00001}: ch = 8'h55; // U
        {3'd3, 5'b00010}: ch = 8'h52; // R
        {3'd3, 5'b00011}: ch = 8'h57; // W
        {3'd3, 5'b00100}: ch = 8'h44; // D
        {3'd3, 5'b00101}: ch = 8'h4B; // K
        {3'd3, 5'b00110}: ch = 8'h47; // G
        {3'd3, 5'b00111}: ch = 8'h4F; // O
        {3'd4, 5'b00000}: ch = 8'h48; // H
        {3'd4, 5'b00001}: ch = 8'h56; // V
        {3'd4, 5'b00010}: ch = 8'h46; // F
        {3'd4, 5'b00100}: ch = 8'h4C; // L
        {3'd4, 5'b00110}: ch = 8'h50; // P
        {3'd4, 5'b00111}: ch = 8'h4A; // J
        {3'd4, 5'b01000}: ch = 8'h42; // B
        {3'd4, 5'b01001}: ch = 8'h58; // X
        {3'd4, 5'b01010}: ch = 8'h43; // C
        {3'd4, 5'b01011}: ch = 8'h59; // Y
        {3'd4, 5'b01100}: ch = 8'h5A; // Z
        {3'd4, 5'b01101}: ch = 8'h51; // Q
        {3'd5, 5'b11111}: ch = 8'h30;
        {3'd5, 5'b01111}: ch = 8'h31;
        {3'd5, 5'b00111}: ch = 8'h32;
        {3'd5, 5'b00011}: ch = 8'h33;
        {3'd5, 5'b00001}: ch = 8'h34;
        {3'd5, 5'b00000}: ch = 8'h35;
        {3'd5, 5'b10000}: ch = 8'h36;
        {3'd5, 5'b11000}: ch = 8'h37;
        {3'd5, 5'b11100}: ch = 8'h38;
        {3'd5, 5'b11110}: ch = 8'h39;
        default:          ch = ASCII_UNKNOWN;
      endcase
    end
    return ch;
  endfunction

endpackage

// File: rtl/morse_key_decoder_if.sv
// Character stream from the decoder towards the UART transmitter path.
interface morse_key_decoder_if;
  import morse_pkg::*;

  logic [7:0] char_data;
  logic       char_valid;
  logic       char_ready;

  modport master (output char_data, output char_valid, input char_ready);
  modport slave  (input char_data, input char_valid, output char_ready);
endinterface

// File: rtl/morse_char_fifo.sv
// First-word-fall-through character FIFO; head reads as zero while empty.
module morse_char_fifo
  import morse_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (Reset || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= din;
  end

  assign dout = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];
endmodule

// File: rtl/morse_key_decoder.sv
// Straight-key Morse decoder: debounces the key, times marks and gaps, and queues ASCII.
module morse_key_decoder
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES     = 50_000_000 / 10,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int MAX_SYMBOLS     = 6,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                       clk,
  input  logic                       Reset,
  input  logic                       Key,
  input  logic                       Clear,
  morse_key_decoder_if.master        chars,
  output logic                       tone,
  output logic                       overflow,
  output logic                       sym_err
);
  localparam int TW = $clog2(8 * UNIT_CYCLES + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [TW-1:0] T_DASH   = TW'(2 * UNIT_CYCLES);
  localparam logic [TW-1:0] T_WORD   = TW'(5 * UNIT_CYCLES);
  localparam logic [TW-1:0] T_MAX    = TW'(8 * UNIT_CYCLES);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]    LEN_MAX  = 3'(MAX_SYMBOLS);

  logic          sync1_reg, sync2_reg, kd_reg, kd_prev_reg;
  logic [DW-1:0] deb_cnt_reg;
  logic [TW-1:0] t_reg;
  state_t        state_reg, state_next;
  logic [2:0]    len_reg, len_next;
  logic [6:0]    pattern_reg, pattern_next;
  logic          err_reg, err_next;
  logic          overflow_reg;
  logic          kd_rise, kd_fall, flush;
  logic          push_raw, push, sym_raw, pop;
  logic [7:0]    push_data;
  logic          fifo_empty, fifo_full;

  always_ff @(posedge clk) begin
    if (Reset) begin
      sync1_reg   <= 1'b0;
      sync2_reg   <= 1'b0;
      kd_reg      <= 1'b0;
      kd_prev_reg <= 1'b0;
      deb_cnt_reg <= '0;
    end else begin
      sync1_reg   <= Key;
      sync2_reg   <= sync1_reg;
      kd_prev_reg <= kd_reg;
      if (sync2_reg == kd_reg) begin
        deb_cnt_reg <= '0;
      end else if (deb_cnt_reg == DEB_LAST) begin
        kd_reg      <= sync2_reg;
        deb_cnt_reg <= '0;
      end else begin
        deb_cnt_reg <= deb_cnt_reg + 1'b1;
      end
    end
  end

  assign kd_rise = kd_reg && !kd_prev_reg;
  assign kd_fall = !kd_reg && kd_prev_reg;
  assign flush   = Reset || Clear;

  // The edge clock already belongs to the new level, so the count restarts at 1
  // and t equals the full level length when the next edge is seen.
  always_ff @(posedge clk) begin
    if (flush)                  t_reg <= '0;
    else if (kd_rise || kd_fall) t_reg <= TW'(1);
    else if (t_reg != T_MAX)    t_reg <= t_reg + 1'b1;
  end

  always_comb begin
    state_next   = state_reg;
    len_next     = len_reg;
    pattern_next = pattern_reg;
    err_next     = err_reg;
    push_raw     = 1'b0;
    push_data    = ASCII_SPACE;
    sym_raw      = 1'b0;
    case (state_reg)
      ST_IDLE: if (kd_rise) state_next = ST_MARK;
      ST_MARK: begin
        if (kd_fall) begin
          state_next = ST_GAP;
          if (len_reg == LEN_MAX) begin
            err_next = 1'b1;
          end else begin
            pattern_next = {pattern_reg[5:0], (t_reg >= T_DASH)};
            len_next     = len_reg + 3'd1;
          end
        end
      end
      ST_GAP: begin
        if (t_reg == T_DASH) begin
          push_raw     = 1'b1;
          push_data    = err_reg ? ASCII_UNKNOWN : morse_lookup(len_reg, pattern_reg);
          sym_raw      = err_reg;
          len_next     = '0;
          pattern_next = '0;
          err_next     = 1'b0;
          state_next   = kd_rise ? ST_MARK : ST_WORD;
        end else if (kd_rise) begin
          state_next = ST_MARK;
        end
      end
      ST_WORD: begin
        if (t_reg == T_WORD) begin
          push_raw   = 1'b1;
          push_data  = ASCII_SPACE;
          state_next = kd_rise ? ST_MARK : ST_IDLE;
        end else if (kd_rise) begin
          state_next = ST_MARK;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      state_reg   <= ST_IDLE;
      len_reg     <= '0;
      pattern_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      len_reg     <= len_next;
      pattern_reg <= pattern_next;
      err_reg     <= err_next;
    end
  end

  assign push    = push_raw && !flush;
  assign sym_err = sym_raw && !flush;
  assign pop     = chars.char_valid && chars.char_ready;

  always_ff @(posedge clk) begin
    if (flush)                           overflow_reg <= 1'b0;
    else if (push && fifo_full && !pop) overflow_reg <= 1'b1;
  end

  morse_char_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .Reset (Reset),
    .flush (Clear),
    .push  (push),
    .din   (push_data),
    .pop   (pop),
    .dout  (chars.char_data),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign chars.char_valid = !fifo_empty;
  assign tone             = kd_reg;
  assign overflow         = overflow_reg;
endmodule

// File: doc/morse_key_decoder.md
# morse_key_decoder

Parametrised successor to the button-driven Morse front end. It decodes a single straight-key input by timing instead of separate Dot/Dash/Space/EndSeq buttons. Mark and gap durations are classified as dot, dash, character end or word space, and each completed character is translated to ASCII. Characters are buffered in an internal FIFO with a valid/ready output that feeds the UART transmitter path.

## Interface
- `UNIT_CYCLES`, default 50_000_000/10: clocks per Morse unit (dot length); must be ≥ 2.
- `DEBOUNCE_CYCLES`, default 500_000: clocks the synchronised key must be stable before it is accepted; ≥ 1.
- `MAX_SYMBOLS`, default 6: maximum dots/dashes per character; range 1–7.
- `FIFO_DEPTH`, default 8: character FIFO entries; power of two, ≥ 2.
- `clk` in, 1: the only clock.
- `Reset` in, 1: synchronous, active-high reset.
- `Key` in, 1: raw asynchronous key level, 1 = pressed.
- `Clear` in, 1: synchronous flush. Aborts the character in progress, empties the FIFO and clears `overflow`.
- `char_data` out, 8: ASCII character at the FIFO head.
- `char_valid` out, 1: `char_data` is valid.
- `char_ready` in, 1: consumer accepts the character; a pop happens when `char_valid && char_ready`.
- `tone` out, 1: debounced key level, for the buzzer.
- `overflow` out, 1: sticky; set when a character is dropped because the FIFO is full.
- `sym_err` out, 1: one-cycle pulse when a character exceeds `MAX_SYMBOLS`.

## Operation
- Input conditioning:
  - Two-flop synchroniser, then a debounce counter.
  - The debounced level `kd` changes only after the synchronised level differs from `kd` for `DEBOUNCE_CYCLES` consecutive clocks.
- Duration timer `t`:
  - Clears on every `kd` edge and increments every clock otherwise.
  - Saturates at `8*UNIT_CYCLES`.
- FSM states and transitions:
  - IDLE: `kd` rising → MARK.
  - MARK: on `kd` falling, classify the mark and go to GAP. `t < 2*UNIT_CYCLES` is a dot (0); otherwise a dash (1). Shift the symbol into `pattern` at the LSB and increment `len`. If `len` would exceed `MAX_SYMBOLS`, set an error flag instead; the extra symbol is discarded.
  - GAP, `kd` rising before `t = 2*UNIT_CYCLES`: intra-character gap → MARK.
  - GAP, `t` reaches `2*UNIT_CYCLES`: push the character. This is ASCII from the lookup, or `?` (0x3F) if the error flag is set or the pattern is not in the table. Clear `len`, `pattern` and the error flag, and pulse `sym_err` if the error flag was set. Go to WORD.
  - WORD, `t` reaches `5*UNIT_CYCLES`: push a space (0x20) → IDLE.
  - WORD, `kd` rising before `5*UNIT_CYCLES`: → MARK, no space pushed.
  - There is exactly one space per word gap. No space is ever pushed before the first character after reset or Clear.
- Lookup table: A–Z and 0–9, keyed on (`len`, `pattern`), first symbol most significant. Examples: `.-` = len 2 / 01 → 0x41; `---` → 0x4F; `-----` → 0x30.
- FIFO behaviour:
  - First-word-fall-through.
  - A push while full with no simultaneous pop drops the character and sets `overflow`.
  - A push and pop in the same cycle while full both succeed and do not set `overflow`.
  - A pop while empty is ignored.
- Clear and Reset:
  - Both apply in the cycle they are sampled. State → IDLE, `t`, `len`, `pattern` and the FIFO pointers → 0, and `overflow` → 0.
  - Reset also clears the synchroniser and the debounce state; Clear does not.
  - Reset has priority over Clear.
  - If the key is still held after Clear, the FSM waits in IDLE for the next `kd` rising edge. The current press is ignored.

## Timing
- Reset values: `char_valid` 0, `char_data` 0x00, `tone` 0, `overflow` 0, `sym_err` 0.
- `Key` edge to `tone` edge: `2 + DEBOUNCE_CYCLES` clocks.
- Character push occurs on the clock where the gap `t` = `2*UNIT_CYCLES`. `char_valid` and `char_data` update on the next clock edge, giving 1-cycle FIFO latency.
- The space push follows at `t` = `5*UNIT_CYCLES`.
- `char_data` is stable while `char_valid && !char_ready`.
- `sym_err` is asserted in the same cycle as the push of `?`.

## Structure
- Package `morse_pkg`:
  - State enum (IDLE, MARK, GAP, WORD).
  - ASCII constants `ASCII_SPACE`, `ASCII_UNKNOWN`.
  - Pure function `morse_lookup(len, pattern)` returning 8 bits.
- Sub-module `morse_char_fifo`: parameters `WIDTH=8`, `DEPTH`; ports `clk`, `Reset`, `flush`, `push`, `din`, `pop`, `dout`, `empty`, `full`.
- Synchroniser and debounce stay inline. Timer width is `$clog2(8*UNIT_CYCLES+1)`.

## Test plan
All scenarios use `UNIT_CYCLES=4`, `DEBOUNCE_CYCLES=2`, `MAX_SYMBOLS=6`, `FIFO_DEPTH=4`, and `char_ready=1` unless stated.
- Key 4 on / 4 off / 12 on / 20 off → exactly 0x41 then 0x20; `sym_err` stays 0.
- "SOS" keyed with 8-clock inter-character gaps, then a 30-clock gap → 0x53, 0x4F, 0x53, 0x20 in order, with no extra spaces.
- Seven dots then a long gap → single 0x3F, `sym_err` high for 1 cycle; the following `.` keys to 0x45.
- Sequence with `char_ready=0`:
  - Key five "E" characters separated by 8-clock gaps, i.e. shorter than the word gap, so no spaces are pushed. → FIFO holds 4×0x45 and `overflow=1`.
  - Then raise `char_ready` → 4 pops, then `char_valid=0`; `overflow` stays 1 until Clear.
- Key glitch of 1 clock, and Reset asserted mid-dash → `tone` never toggles for the glitch. After Reset all outputs are at reset values, and the next full "T" (dash) yields 0x54.
- Clear while the FIFO holds 2 characters and a dot is in progress → FIFO empty the next cycle, no partial character emitted, `overflow=0`.
